// File: rtl/iscas_scan_misr.sv
// rtl/iscas_scan_misr.sv - scan-chain state register with MISR compaction of core outputs
// Optional MISR_SEED_EN adds a SEED port that loads SIG at test start (default: SIG cleared).
module iscas_scan_misr #(
  parameter int               WIDTH = 19,
  parameter int               PO_W  = 23,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h8016)
) (
  input  logic               CK,
  input  logic               RN,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  input  logic [PO_W-1:0]    PO,
  input  logic               SI,
  output logic               SO,
  input  logic               TEST_REQ,
  input  logic [15:0]        NPAT,
  output logic               BUSY,
  output logic               DONE,
  output logic [SIG_W-1:0]   SIG
`ifdef MISR_SEED_EN
  ,
  input  logic [SIG_W-1:0]   SEED
`endif
);

  localparam int SCW = $clog2(WIDTH + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SCW-1:0]   shift_cnt;
  logic [SCW-1:0]   shift_cnt_nx;
  logic [15:0]      pat_cnt;
  logic [15:0]      pat_cnt_nx;
  logic [15:0]      pat_cnt_inc;
  logic [15:0]      npat_q;
  logic [15:0]      npat_nx;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_shift;
  logic [SIG_W-1:0] sig_r;
  logic [SIG_W-1:0] sig_nx;
  logic [SIG_W-1:0] sig_seed;
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] misr_nx;
  logic             busy_r;
  logic             done_r;

`ifdef MISR_SEED_EN
  assign sig_seed = SEED;
`else
  assign sig_seed = '0;
`endif

  // PO bit i folds onto signature bit (i mod SIG_W)
  always_comb begin
    fold = '0;
    for (int i = 0; i < PO_W; i++) begin
      fold[i % SIG_W] = fold[i % SIG_W] ^ PO[i];
    end
  end

  assign misr_nx     = {sig_r[SIG_W-2:0], 1'b0} ^ (sig_r[SIG_W-1] ? POLY : '0) ^ fold;
  assign q_shift     = {q_r[WIDTH-2:0], SI};
  assign pat_cnt_inc = pat_cnt + 16'd1;

  always_comb begin
    state_nx     = state;
    shift_cnt_nx = shift_cnt;
    pat_cnt_nx   = pat_cnt;
    npat_nx      = npat_q;
    q_nx         = q_r;
    sig_nx       = sig_r;
    case (state)
      IDLE: begin
        q_nx = D;
        if (TEST_REQ) begin
          npat_nx      = NPAT;
          shift_cnt_nx = '0;
          pat_cnt_nx   = '0;
          sig_nx       = sig_seed;
          state_nx     = (NPAT == 16'd0) ? FIN : SHIFT;
        end
      end
      SHIFT: begin
        q_nx         = q_shift;
        shift_cnt_nx = shift_cnt + 1'b1;
        if (shift_cnt == SHIFT_LAST) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        q_nx       = D;
        sig_nx     = misr_nx;
        pat_cnt_nx = pat_cnt_inc;
        if (pat_cnt_inc == npat_q) begin
          state_nx = FIN;
        end else begin
          state_nx     = SHIFT;
          shift_cnt_nx = '0;
        end
      end
      FIN: begin
        q_nx     = D;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      npat_q    <= '0;
      q_r       <= '0;
      sig_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_cnt <= shift_cnt_nx;
      pat_cnt   <= pat_cnt_nx;
      npat_q    <= npat_nx;
      q_r       <= q_nx;
      sig_r     <= sig_nx;
      // status flags are decoded from the next state so they align with the state register
      busy_r    <= (state_nx == SHIFT) || (state_nx == CAPTURE);
      done_r    <= (state_nx == FIN);
    end
  end

  assign Q    = q_r;
  assign SO   = q_r[WIDTH-1];
  assign SIG  = sig_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_iscas_scan_misr.sv
// tb/tb_iscas_scan_misr.sv - randomized self-checking bench for iscas_scan_misr
// Define MISR_SEED_EN to exercise the SEED port.
module tb_iscas_scan_misr;

  localparam int          W    = 19;
  localparam int          PW   = 23;
  localparam logic [15:0] POLY = 16'h8016;

  logic          CK;
  logic          RN;
  logic [W-1:0]  D;
  logic [W-1:0]  Q;
  logic [PW-1:0] PO;
  logic          SI;
  logic          SO;
  logic          TEST_REQ;
  logic [15:0]   NPAT;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   SIG;
`ifdef MISR_SEED_EN
  logic [15:0]   SEED;
`endif

  int checks;
  int failures;

  logic [W-1:0] mq;
  logic [15:0]  msig;

  iscas_scan_misr dut (
    .CK       (CK),
    .RN       (RN),
    .D        (D),
    .Q        (Q),
    .PO       (PO),
    .SI       (SI),
    .SO       (SO),
    .TEST_REQ (TEST_REQ),
    .NPAT     (NPAT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SIG      (SIG)
`ifdef MISR_SEED_EN
    ,
    .SEED     (SEED)
`endif
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // PO bit i lands on signature bit i mod 16: fold the upper 7 bits onto the lower word
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [PW-1:0] p);
    logic [15:0] f;
    f = p[15:0] ^ 16'(p >> 16);
    return 16'(s << 1) ^ (s[15] ? POLY : 16'h0000) ^ f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      TEST_REQ = 1'b0;
      D  = W'($urandom);
      PO = PW'($urandom);
      SI = 1'($urandom);
      mq = D;
      tick();
      check("idle_q", 64'(Q), 64'(mq));
      check("idle_sig_hold", 64'(SIG), 64'(msig));
      check("idle_busy", 64'(BUSY), 64'd0);
      check("idle_done", 64'(DONE), 64'd0);
    end
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after FIN.
  task automatic run_test(input int npat, input bit rnd, input logic [W-1:0] dfix,
                          input logic [PW-1:0] pofix, input bit sifix, input bit hold_req);
    int total;
    int r;
    TEST_REQ = 1'b1;
    NPAT     = 16'(npat);
    D        = rnd ? W'($urandom) : dfix;
    PO       = rnd ? PW'($urandom) : pofix;
    SI       = rnd ? 1'($urandom) : sifix;
`ifdef MISR_SEED_EN
    SEED     = 16'($urandom);
    msig     = SEED;
`else
    msig     = 16'h0000;
`endif
    mq    = D;
    total = (npat == 0) ? 1 : npat * (W + 1) + 1;
    tick();
    for (int c = 1; c <= total; c++) begin
      check("busy", 64'(BUSY), 64'(c < total));
      check("done", 64'(DONE), 64'(c == total));
      check("q", 64'(Q), 64'(mq));
      check("so", 64'(SO), 64'(mq[W-1]));
      check("sig", 64'(SIG), 64'(msig));
      TEST_REQ = (c == total) ? hold_req : 1'($urandom);
      NPAT     = 16'($urandom);
      D        = rnd ? W'($urandom) : dfix;
      PO       = rnd ? PW'($urandom) : pofix;
      SI       = rnd ? 1'($urandom) : sifix;
      if (c == total) begin
        mq = D;
      end else begin
        r = (c - 1) % (W + 1);
        if (r < W) begin
          mq = {mq[W-2:0], SI};
        end else begin
          mq   = D;
          msig = misr(msig, PO);
        end
      end
      tick();
    end
    check("post_busy", 64'(BUSY), 64'd0);
    check("post_done", 64'(DONE), 64'd0);
    check("post_q", 64'(Q), 64'(mq));
    check("post_sig", 64'(SIG), 64'(msig));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RN       = 1'b0;
    D        = '0;
    PO       = '0;
    SI       = 1'b0;
    TEST_REQ = 1'b0;
    NPAT     = '0;
`ifdef MISR_SEED_EN
    SEED     = '0;
`endif
    repeat (2) @(posedge CK);
    #1;
    check("rst_q", 64'(Q), 64'd0);
    check("rst_so", 64'(SO), 64'd0);
    check("rst_sig", 64'(SIG), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    RN   = 1'b1;
    msig = 16'h0000;
    idle(3);

    run_test(1, 1'b0, 19'h5A5A5, '0, 1'b1, 1'b0);
`ifndef MISR_SEED_EN
    check("single_sig", 64'(SIG), 64'h0000);
`endif
    check("single_q", 64'(Q), 64'h5A5A5);
    idle(2);

    run_test(0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(2);

    run_test(3, 1'b0, W'($urandom), 23'h000001, 1'b0, 1'b0);
`ifndef MISR_SEED_EN
    check("three_pat_sig", 64'(SIG), 64'h0007);
`endif
    idle(3);

    run_test(2, 1'b1, '0, '0, 1'b0, 1'b1);
    run_test(1, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(2);

`ifdef MISR_SEED_EN
    TEST_REQ = 1'b1;
    NPAT     = 16'd1;
    SEED     = 16'h8000;
    PO       = '0;
    tick();
    TEST_REQ = 1'b0;
    repeat (W + 1) tick();
    check("seed_sig", 64'(SIG), 64'h8016);
    tick();
    msig = SIG;
    idle(1);
`endif

    // reset asserted in the 7th shift cycle
    TEST_REQ = 1'b1;
    NPAT     = 16'd5;
    D        = W'($urandom);
    tick();
    TEST_REQ = 1'b0;
    for (int k = 0; k < 6; k++) begin
      SI = 1'($urandom);
      tick();
    end
    check("mid_busy_pre", 64'(BUSY), 64'd1);
    #2;
    RN = 1'b0;
    #1;
    check("mid_rst_q", 64'(Q), 64'd0);
    check("mid_rst_sig", 64'(SIG), 64'd0);
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_done", 64'(DONE), 64'd0);
    check("mid_rst_so", 64'(SO), 64'd0);
    tick();
    RN   = 1'b1;
    msig = 16'h0000;
    idle(4);

    run_test(4, 1'b1, '0, '0, 1'b0, 1'b0);
    run_test(2, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iscas_scan_misr.md
ISCAS_SCAN_MISR -- requirements
Module: iscas_scan_misr

Interface
REQ-001 SHALL have parameter WIDTH, default 19, number of state flip-flops (2..64).
REQ-002 SHALL have parameter PO_W, default 23, number of observed primary outputs (1..128).
REQ-003 SHALL have parameter SIG_W, default 16, MISR signature width (4..32).
REQ-004 SHALL have parameter POLY, default 16'h8016, MISR feedback taps, SIG_W bits.
REQ-005 SHALL have port CK  input  1  rising-edge clock, the only clock.
REQ-006 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-007 SHALL have port D  input  WIDTH  next-state from the benchmark core logic.
REQ-008 SHALL have port Q  output  WIDTH  registered state driven to the core logic.
REQ-009 SHALL have port PO  input  PO_W  core primary outputs to be compacted.
REQ-010 SHALL have port SI  input  1  scan data in.
REQ-011 SHALL have port SO  output  1  scan data out, equal to Q[WIDTH-1].
REQ-012 SHALL have port TEST_REQ  input  1  level request to start a test sequence.
REQ-013 SHALL have port NPAT  input  16  pattern count, sampled when a test starts.
REQ-014 SHALL have port BUSY  output  1  high in SHIFT and CAPTURE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse at end of test.
REQ-016 SHALL have port SIG  output  SIG_W  current MISR signature.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, CAPTURE, FIN.
REQ-018 In IDLE, Q SHALL load D every cycle (functional mode), and SIG SHALL hold.
REQ-019 IDLE with TEST_REQ=1 SHALL go to SHIFT, latch NPAT, clear the shift and pattern counters, and initialise SIG (REQ-032).
REQ-020 IDLE with TEST_REQ=1 and NPAT=0 SHALL go directly to FIN, leaving Q and SIG unchanged after initialisation.
REQ-021 In SHIFT, Q SHALL be updated each cycle to {Q[WIDTH-2:0],SI}, and the shift counter SHALL increment.
REQ-022 After exactly WIDTH SHIFT cycles, the FSM SHALL go to CAPTURE.
REQ-023 CAPTURE SHALL last one cycle, with Q loading D and SIG compacting PO sampled in that cycle.
REQ-024 MISR update: next SIG = (SIG<<1) XOR (SIG[SIG_W-1] ? POLY : 0) XOR F, where F bit j = XOR of all PO[i] with i mod SIG_W = j.
REQ-025 After CAPTURE, the pattern counter SHALL increment, and the FSM SHALL go to FIN if the count equals the latched NPAT, else to SHIFT with the shift counter cleared.
REQ-026 FIN SHALL last one cycle with DONE=1, Q loading D, and SIG holding, then return to IDLE.
REQ-027 TEST_REQ SHALL be ignored outside IDLE, and NPAT changes during a test SHALL have no effect.
REQ-028 TEST_REQ held high through FIN SHALL start a new test on the cycle after return to IDLE.
REQ-029 BUSY SHALL be a registered decode: 1 in SHIFT and CAPTURE, 0 in IDLE and FIN.
REQ-030 Counter widths SHALL be clog2(WIDTH+1) for the shift counter and 16 for the pattern counter, with no wrap reachable.

Reset
REQ-031 RN=0 SHALL immediately force state IDLE, Q=0, SO=0, SIG=0, BUSY=0, DONE=0, and all counters to 0, including when asserted mid-SHIFT or mid-CAPTURE; operation SHALL resume in IDLE at the first CK edge after RN rises.

Configuration
REQ-032 Macro MISR_SEED_EN: when defined, the block SHALL add port SEED input SIG_W, and SIG SHALL be loaded from SEED at test start; when undefined, there SHALL be no SEED port and SIG SHALL be cleared to 0 at test start.

Verification
REQ-033 Reset mid-SHIFT (cycle 7 of 19) -> next cycle Q=0, SIG=0, BUSY=0, state IDLE; no DONE pulse.
REQ-034 Defaults, NPAT=1, SI=1 for 19 cycles, D=0x5A5A5, PO=0 -> Q=0x7FFFF before CAPTURE, Q=0x5A5A5 after, SIG=0x0000, DONE pulses at cycle 21 after start.
REQ-035 NPAT=0 -> DONE pulses on the cycle after start, BUSY never 1, SIG=0.
REQ-036 NPAT=3, PO=bit0 only each CAPTURE -> SIG=0x0001, 0x0003, 0x0007 after each CAPTURE; total 61 cycles start-to-DONE.
REQ-037 TEST_REQ pulsed during SHIFT, and NPAT changed mid-test -> no restart; pattern count uses the latched value.
REQ-038 With MISR_SEED_EN, SEED=0x8000, NPAT=1, PO=0 -> SIG=0x8016 after CAPTURE.
